// File: rtl/calc_port_scheduler_if.sv
// Bus bundle for the calc port scheduler: four requester ports plus the tagged ALU link.
// The scheduler uses the slave view; the requesters/ALU environment uses the master view.
interface calc_port_scheduler_if #(
    parameter int DATA_W = 32
);
    logic [3:0]        req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
    logic [DATA_W-1:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
    logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
    logic [1:0]        out_resp1, out_resp2, out_resp3, out_resp4;
    logic              alu_req;
    logic [3:0]        alu_cmd;
    logic [DATA_W-1:0] alu_op1, alu_op2;
    logic [1:0]        alu_tag;
    logic              alu_ack;
    logic              alu_done;
    logic [1:0]        alu_done_tag;
    logic [DATA_W-1:0] alu_result;
    logic [1:0]        alu_resp;
    logic [3:0]        overrun;

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        output out_data1, out_data2, out_data3, out_data4,
        output out_resp1, out_resp2, out_resp3, out_resp4,
        output alu_req, alu_cmd, alu_op1, alu_op2, alu_tag,
        input  alu_ack, alu_done, alu_done_tag, alu_result, alu_resp,
        output overrun
    );

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        input  out_data1, out_data2, out_data3, out_data4,
        input  out_resp1, out_resp2, out_resp3, out_resp4,
        input  alu_req, alu_cmd, alu_op1, alu_op2, alu_tag,
        output alu_ack, alu_done, alu_done_tag, alu_result, alu_resp,
        input  overrun
    );
endinterface

// File: rtl/calc_port_scheduler.sv
// Shares one tagged two-operand ALU between four calc-protocol ports: capture, filter,
// round-robin issue, tagged completion routing and a per-request watchdog.
module calc_port_scheduler #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input logic                  c_clk,
    input logic                  reset,
    calc_port_scheduler_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, OP2, PEND, ISSUED, RESP} state_t;

    state_t            state_q [4];
    state_t            state_d [4];
    logic [3:0]        cmd_in  [4];
    logic [DATA_W-1:0] data_in [4];
    logic [3:0]        cmd_q   [4];
    logic [DATA_W-1:0] op1_q   [4];
    logic [DATA_W-1:0] op2_q   [4];
    logic [DATA_W-1:0] rdata_q [4];
    logic [1:0]        resp_q  [4];
    logic [WD_W-1:0]   wd_q    [4];
    logic [DATA_W-1:0] out_data [4];
    logic [1:0]        out_resp [4];
    logic [3:0]        pend, done_hit, expire, ovr_set, overrun_q;
    logic [1:0]        ptr_q, sel_q, sel;
    logic              lock_q, req, grant;

    function automatic logic valid_cmd(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    assign cmd_in[0]  = bus.req1_cmd_in;
    assign cmd_in[1]  = bus.req2_cmd_in;
    assign cmd_in[2]  = bus.req3_cmd_in;
    assign cmd_in[3]  = bus.req4_cmd_in;
    assign data_in[0] = bus.req1_data_in;
    assign data_in[1] = bus.req2_data_in;
    assign data_in[2] = bus.req3_data_in;
    assign data_in[3] = bus.req4_data_in;

    assign bus.out_data1 = out_data[0];
    assign bus.out_data2 = out_data[1];
    assign bus.out_data3 = out_data[2];
    assign bus.out_data4 = out_data[3];
    assign bus.out_resp1 = out_resp[0];
    assign bus.out_resp2 = out_resp[1];
    assign bus.out_resp3 = out_resp[2];
    assign bus.out_resp4 = out_resp[3];
    assign bus.overrun   = overrun_q;

    always_comb begin
        pend     = '0;
        done_hit = '0;
        expire   = '0;
        for (int p = 0; p < 4; p++) begin
            pend[p]     = (state_q[p] == PEND);
            done_hit[p] = bus.alu_done && (bus.alu_done_tag == 2'(p));
            expire[p]   = (TIMEOUT > 0) && (wd_q[p] >= WD_LAST);
            out_resp[p] = (state_q[p] == RESP) ? resp_q[p] : 2'd0;
            out_data[p] = (state_q[p] == RESP) ? rdata_q[p] : '0;
        end
    end

    // Once a request is shown without ack, the choice is frozen until accepted.
    always_comb begin
        sel = sel_q;
        if (!lock_q) begin
            sel = ptr_q;
            for (int k = 4; k >= 1; k--) begin
                if (pend[ptr_q + 2'(k)]) sel = ptr_q + 2'(k);
            end
        end
    end

    assign req         = |pend;
    assign grant       = req && bus.alu_ack;
    assign bus.alu_req = req;
    assign bus.alu_tag = req ? sel : 2'd0;
    assign bus.alu_cmd = req ? cmd_q[sel] : 4'd0;
    assign bus.alu_op1 = req ? op1_q[sel] : '0;
    assign bus.alu_op2 = req ? op2_q[sel] : '0;

    always_comb begin
        ovr_set = '0;
        for (int p = 0; p < 4; p++) begin
            state_d[p] = state_q[p];
            case (state_q[p])
                IDLE:    if (cmd_in[p] != 4'd0) state_d[p] = OP2;
                OP2:     state_d[p] = valid_cmd(cmd_q[p]) ? PEND : RESP;
                PEND:    if (grant && (sel == 2'(p))) state_d[p] = ISSUED;
                ISSUED:  if (done_hit[p] || expire[p]) state_d[p] = RESP;
                RESP:    state_d[p] = IDLE;
                default: state_d[p] = IDLE;
            endcase
            // Port N's overrun flag lives at bit N, so port 4 wraps onto bit 0.
            if ((cmd_in[p] != 4'd0) && (state_q[p] inside {PEND, ISSUED, RESP}))
                ovr_set[2'(p + 1)] = 1'b1;
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            for (int p = 0; p < 4; p++) state_q[p] <= IDLE;
            ptr_q     <= 2'd3;
            sel_q     <= 2'd0;
            lock_q    <= 1'b0;
            overrun_q <= 4'd0;
        end else begin
            for (int p = 0; p < 4; p++) state_q[p] <= state_d[p];
            if (grant) ptr_q <= sel;
            sel_q     <= sel;
            lock_q    <= req && !bus.alu_ack;
            overrun_q <= overrun_q | ovr_set;
        end
    end

    // Payload registers carry no reset; every output is qualified by port state.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < 4; p++) begin
            case (state_q[p])
                IDLE: begin
                    if (cmd_in[p] != 4'd0) begin
                        cmd_q[p] <= cmd_in[p];
                        op1_q[p] <= data_in[p];
                    end
                end
                OP2: begin
                    op2_q[p]   <= data_in[p];
                    resp_q[p]  <= 2'd2;
                    rdata_q[p] <= '0;
                end
                PEND: wd_q[p] <= WD_W'(1);
                ISSUED: begin
                    wd_q[p] <= wd_q[p] + 1'b1;
                    if (done_hit[p]) begin
                        resp_q[p]  <= bus.alu_resp;
                        rdata_q[p] <= bus.alu_result;
                    end else begin
                        resp_q[p]  <= 2'd3;
                        rdata_q[p] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_port_scheduler.sv
// Directed bench for calc_port_scheduler: stimulus queues expected grants and port responses
// (with their cycle numbers); a negedge monitor pops and compares whenever the DUT presents one.
module tb_calc_port_scheduler;
    logic c_clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    typedef struct {logic [1:0] resp; logic [31:0] data; int cyc;} rexp_t;
    typedef struct {logic [1:0] tag; logic [3:0] cmd; logic [31:0] op1; logic [31:0] op2; int cyc;} gexp_t;
    rexp_t rq [4][$];
    gexp_t gq [$];

    calc_port_scheduler_if #(.DATA_W(32)) bus ();
    calc_port_scheduler #(.DATA_W(32), .TIMEOUT(8)) dut (.c_clk(c_clk), .reset(reset), .bus(bus));

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    logic [1:0]  oresp [4];
    logic [31:0] odata [4];
    assign oresp[0] = bus.out_resp1;
    assign oresp[1] = bus.out_resp2;
    assign oresp[2] = bus.out_resp3;
    assign oresp[3] = bus.out_resp4;
    assign odata[0] = bus.out_data1;
    assign odata[1] = bus.out_data2;
    assign odata[2] = bus.out_data3;
    assign odata[3] = bus.out_data4;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge c_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d);
        case (p)
            1: begin bus.req1_cmd_in = c; bus.req1_data_in = d; end
            2: begin bus.req2_cmd_in = c; bus.req2_data_in = d; end
            3: begin bus.req3_cmd_in = c; bus.req3_data_in = d; end
            default: begin bus.req4_cmd_in = c; bus.req4_data_in = d; end
        endcase
    endtask

    task automatic exp_resp(input int p, input logic [1:0] r, input logic [31:0] d, input int c);
        rexp_t e;
        e = '{r, d, c};
        rq[p-1].push_back(e);
    endtask

    task automatic exp_grant(input int tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int at);
        gexp_t e;
        e = '{2'(tag), c, a, b, at};
        gq.push_back(e);
    endtask

    task automatic send(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        set_port(p, c, a);
        tick(1);
        set_port(p, 4'd0, b);
        tick(1);
        set_port(p, 4'd0, 32'd0);
    endtask

    task automatic done(input int tag, input logic [31:0] res, input logic [1:0] rsp, input bit want);
        bus.alu_done     = 1'b1;
        bus.alu_done_tag = 2'(tag);
        bus.alu_result   = res;
        bus.alu_resp     = rsp;
        if (want) exp_resp(tag + 1, rsp, res, cyc + 1);
        tick(1);
        bus.alu_done     = 1'b0;
        bus.alu_done_tag = 2'd0;
        bus.alu_result   = 32'd0;
        bus.alu_resp     = 2'd0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_resp"}, 160'({bus.out_resp1, bus.out_resp2, bus.out_resp3, bus.out_resp4}), 160'd0);
        check({name, "_data"}, 160'({bus.out_data1, bus.out_data2, bus.out_data3, bus.out_data4}), 160'd0);
        check({name, "_alu"}, 160'({bus.alu_req, bus.alu_cmd, bus.alu_op1, bus.alu_op2, bus.alu_tag}), 160'd0);
        check({name, "_overrun"}, 160'(bus.overrun), 160'd0);
    endtask

    always @(negedge c_clk) begin
        if (mon_en) begin
            if (bus.alu_req && bus.alu_ack) begin
                n_tests++;
                if (gq.size() == 0) begin
                    n_fail++;
                    $display("FAIL grant_unexpected cycle=%0d got tag=%0d cmd=%0d required no grant", cyc, bus.alu_tag, bus.alu_cmd);
                end else begin
                    gexp_t g;
                    g = gq.pop_front();
                    if (bus.alu_tag !== g.tag || bus.alu_cmd !== g.cmd || bus.alu_op1 !== g.op1 || bus.alu_op2 !== g.op2 || cyc != g.cyc) begin
                        n_fail++;
                        $display("FAIL grant got tag=%0d cmd=%0d op1=%0h op2=%0h cycle=%0d expected tag=%0d cmd=%0d op1=%0h op2=%0h cycle=%0d",
                                 bus.alu_tag, bus.alu_cmd, bus.alu_op1, bus.alu_op2, cyc, g.tag, g.cmd, g.op1, g.op2, g.cyc);
                    end
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (oresp[p] != 2'd0) begin
                    n_tests++;
                    if (rq[p].size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected port%0d cycle=%0d got resp=%0d data=%0h required none", p + 1, cyc, oresp[p], odata[p]);
                    end else begin
                        rexp_t e;
                        e = rq[p].pop_front();
                        if (oresp[p] !== e.resp || odata[p] !== e.data || cyc != e.cyc) begin
                            n_fail++;
                            $display("FAIL resp port%0d got resp=%0d data=%0h cycle=%0d expected resp=%0d data=%0h cycle=%0d",
                                     p + 1, oresp[p], odata[p], cyc, e.resp, e.data, e.cyc);
                        end
                    end
                end else if (odata[p] != 32'd0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL idle_data port%0d cycle=%0d got data=%0h required 0", p + 1, cyc, odata[p]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached at cycle=%0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int t0;
        for (int p = 1; p <= 4; p++) set_port(p, 4'd0, 32'd0);
        bus.alu_ack = 1'b1;
        bus.alu_done = 1'b0;
        bus.alu_done_tag = 2'd0;
        bus.alu_result = 32'd0;
        bus.alu_resp = 2'd0;
        reset = 1'b0;
        tick(3);
        check_quiet("reset_state");
        reset = 1'b1;
        mon_en = 1'b1;
        tick(1);

        // All four ports request together: tags 0..3 on consecutive cycles, then completions out of order.
        t0 = cyc;
        for (int p = 0; p < 4; p++) exp_grant(p, 4'd2, 32'(100 * (p + 1)), 32'(p + 1), t0 + 2 + p);
        for (int p = 1; p <= 4; p++) set_port(p, 4'd2, 32'(100 * p));
        tick(1);
        for (int p = 1; p <= 4; p++) set_port(p, 4'd0, 32'(p));
        tick(1);
        for (int p = 1; p <= 4; p++) set_port(p, 4'd0, 32'd0);
        tick(4);
        done(2, 32'd297, 2'd1, 1'b1);
        done(0, 32'd99, 2'd1, 1'b1);
        done(3, 32'd396, 2'd1, 1'b1);
        done(1, 32'd198, 2'd1, 1'b1);
        tick(2);

        // Ports 2 and 4 re-request together with pointer on port 4: port 2 wins first.
        t0 = cyc;
        exp_grant(1, 4'd1, 32'd10, 32'd20, t0 + 2);
        exp_grant(3, 4'd5, 32'd1, 32'd4, t0 + 3);
        set_port(2, 4'd1, 32'd10);
        set_port(4, 4'd5, 32'd1);
        tick(1);
        set_port(2, 4'd0, 32'd20);
        set_port(4, 4'd0, 32'd4);
        tick(1);
        set_port(2, 4'd0, 32'd0);
        set_port(4, 4'd0, 32'd0);
        tick(2);
        done(3, 32'd16, 2'd1, 1'b1);
        done(1, 32'd30, 2'd1, 1'b1);
        tick(2);

        // Port 1 add 5 + 7, done three cycles after ack.
        t0 = cyc;
        exp_grant(0, 4'd1, 32'h5, 32'h7, t0 + 2);
        send(1, 4'd1, 32'h5, 32'h7);
        tick(3);
        done(0, 32'hC, 2'd1, 1'b1);
        tick(2);

        // Invalid command 3 on port 3: no ALU request, resp 2 one cycle after operand 2.
        set_port(3, 4'd3, 32'h1);
        tick(1);
        set_port(3, 4'd0, 32'h2);
        exp_resp(3, 2'd2, 32'd0, cyc + 1);
        tick(1);
        set_port(3, 4'd0, 32'd0);
        tick(3);

        // Second command on port 2 while its first is issued.
        t0 = cyc;
        exp_grant(1, 4'd1, 32'd3, 32'd4, t0 + 2);
        send(2, 4'd1, 32'd3, 32'd4);
        tick(1);
        set_port(2, 4'd1, 32'd9);
        tick(1);
        set_port(2, 4'd0, 32'd9);
        tick(1);
        set_port(2, 4'd0, 32'd0);
        check("overrun_port2", 160'(bus.overrun), 160'(4'b0100));
        done(1, 32'd7, 2'd1, 1'b1);
        tick(3);

        // Watchdog expiry on port 4, then a late done that must be ignored.
        t0 = cyc;
        exp_grant(3, 4'd1, 32'd2, 32'd3, t0 + 2);
        exp_resp(4, 2'd3, 32'd0, t0 + 10);
        send(4, 4'd1, 32'd2, 32'd3);
        tick(10);
        done(3, 32'd5, 2'd1, 1'b0);
        tick(2);

        // Done arriving in the expiry cycle wins over the timeout.
        t0 = cyc;
        exp_grant(3, 4'd2, 32'd9, 32'd4, t0 + 2);
        send(4, 4'd2, 32'd9, 32'd4);
        tick(7);
        done(3, 32'd5, 2'd1, 1'b1);
        tick(2);

        // Reset with ports 1,2 issued and port 3 pending.
        t0 = cyc;
        exp_grant(0, 4'd1, 32'd1, 32'd11, t0 + 2);
        exp_grant(1, 4'd1, 32'd2, 32'd12, t0 + 3);
        set_port(1, 4'd1, 32'd1);
        set_port(2, 4'd1, 32'd2);
        tick(1);
        set_port(1, 4'd0, 32'd11);
        set_port(2, 4'd0, 32'd12);
        tick(1);
        set_port(1, 4'd0, 32'd0);
        set_port(2, 4'd0, 32'd0);
        tick(2);
        bus.alu_ack = 1'b0;
        send(3, 4'd2, 32'd5, 32'd6);
        check("pend_before_reset", 160'({bus.alu_req, bus.alu_tag}), 160'({1'b1, 2'd2}));
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        bus.alu_ack = 1'b1;
        check_quiet("after_reset");
        done(0, 32'hDEAD, 2'd1, 1'b0);
        done(1, 32'hBEEF, 2'd1, 1'b0);
        tick(1);
        t0 = cyc;
        exp_grant(0, 4'd1, 32'h20, 32'h30, t0 + 2);
        send(1, 4'd1, 32'h20, 32'h30);
        tick(1);
        done(0, 32'h50, 2'd1, 1'b1);
        tick(2);

        // Stalled request stays selected when a higher-priority port becomes pending.
        bus.alu_ack = 1'b0;
        set_port(4, 4'd1, 32'h11);
        tick(1);
        set_port(4, 4'd0, 32'h22);
        set_port(2, 4'd2, 32'h33);
        tick(1);
        set_port(4, 4'd0, 32'd0);
        set_port(2, 4'd0, 32'h44);
        tick(1);
        set_port(2, 4'd0, 32'd0);
        check("stall_hold", 160'({bus.alu_req, bus.alu_tag, bus.alu_op1}), 160'({1'b1, 2'd3, 32'h11}));
        exp_grant(3, 4'd1, 32'h11, 32'h22, cyc);
        exp_grant(1, 4'd2, 32'h33, 32'h44, cyc + 1);
        bus.alu_ack = 1'b1;
        tick(3);
        done(3, 32'h33, 2'd1, 1'b1);
        done(1, 32'hFFFF_FFEF, 2'd2, 1'b1);
        tick(3);

        check("grants_drained", 160'(gq.size()), 160'd0);
        for (int p = 0; p < 4; p++) check("responses_drained", 160'(rq[p].size()), 160'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
